// File: rtl/nn_pkg.sv
// nn_pkg: shared fixed-point types and sequencer state encoding for the nn layer blocks
package nn_pkg;
  localparam int DATA_W = 8;
  localparam int FRAC_W = 5;
  localparam int ACC_W = 13;
  typedef logic signed [DATA_W-1:0] q3_5_t;
  typedef logic signed [ACC_W-1:0] q8_5_t;
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, ACT, OUT} seq_state_t;
endpackage

// File: rtl/nn_bias_relu_sat.sv
// nn_bias_relu_sat: adds a Q3.5 bias to a Q8.5 sum, then ReLU and clamp to 0..127
module nn_bias_relu_sat
  import nn_pkg::*;
(
  input  q8_5_t sum,
  input  q3_5_t bias,
  output q3_5_t result
);
  logic [13:0] s;
  always_comb begin
    s = {sum[ACC_W-1], sum} + {{(14-DATA_W){bias[DATA_W-1]}}, bias};
    result = s[13] ? q3_5_t'(0) : (|s[12:7]) ? q3_5_t'(127) : q3_5_t'(s[7:0]);
  end
endmodule

// File: rtl/neuron_sequencer.sv
// neuron_sequencer: drives one perceptron through clear/stream/drain/activate per neuron
// and emits one biased, rectified, saturated Q3.5 result per neuron over valid/ready.
module neuron_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_INPUTS = 784,
  parameter int NUM_NEURONS = 10,
  localparam int XA_W = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1,
  localparam int WA_W = NUM_INPUTS * NUM_NEURONS > 1 ? $clog2(NUM_INPUTS * NUM_NEURONS) : 1,
  localparam int NA_W = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            x_rd_en,
  output logic [XA_W-1:0] x_addr,
  input  logic [7:0]      x_rdata,
  output logic [WA_W-1:0] w_addr,
  input  logic [7:0]      w_rdata,
  output logic            b_rd_en,
  output logic [NA_W-1:0] b_addr,
  input  logic [7:0]      b_rdata,
  output logic            acc_clr,
  output logic            acc_en,
  output logic [7:0]      acc_data,
  output logic [7:0]      acc_weight,
  input  logic [12:0]     acc_sum,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic [NA_W-1:0] out_index
);
  seq_state_t state, state_n;
  logic [XA_W-1:0] inp;
  logic [WA_W-1:0] waddr;
  logic [NA_W-1:0] neuron;
  q3_5_t bias_q, res;
  logic last_in, last_n, hs;
  assign last_in = inp == XA_W'(NUM_INPUTS - 1);
  assign last_n = neuron == NA_W'(NUM_NEURONS - 1);
  assign hs = out_valid && out_ready;
  assign x_addr = inp;
  assign w_addr = waddr;
  assign b_addr = neuron;
  assign acc_data = x_rdata;
  assign acc_weight = w_rdata;
  nn_bias_relu_sat u_brs (
    .sum(acc_sum),
    .bias(bias_q),
    .result(res)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? CLEAR : IDLE;
      CLEAR:   state_n = STREAM;
      STREAM:  state_n = last_in ? DRAIN : STREAM;
      DRAIN:   state_n = ACT;
      ACT:     state_n = OUT;
      OUT:     state_n = hs ? (last_n ? IDLE : CLEAR) : OUT;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    x_rd_en = state == STREAM;
    b_rd_en = state == CLEAR;
    acc_clr = state == CLEAR;
  end
  // waddr runs continuously across neurons, which equals neuron*NUM_INPUTS+input without a multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      neuron <= '0;
      inp <= '0;
      waddr <= '0;
      bias_q <= '0;
      acc_en <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_index <= '0;
      done <= 1'b0;
    end else begin
      acc_en <= x_rd_en;
      done <= state == OUT && hs && last_n;
      case (state)
        IDLE: if (start) begin
          neuron <= '0;
          waddr <= '0;
        end
        CLEAR: inp <= '0;
        STREAM: begin
          inp <= inp + 1'b1;
          waddr <= waddr + 1'b1;
          if (inp == '0) bias_q <= b_rdata;
        end
        ACT: begin
          out_data <= res;
          out_index <= neuron;
          out_valid <= 1'b1;
        end
        OUT: if (hs) begin
          out_valid <= 1'b0;
          if (!last_n) neuron <= neuron + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_sequencer.sv
// tb_neuron_sequencer: directed bench with behavioural memories and perceptron accumulator
module tb_neuron_sequencer;
  localparam int NI = 4;
  localparam int NN = 2;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic busy, done, x_rd_en, b_rd_en, acc_clr, acc_en, out_valid;
  logic [1:0] x_addr;
  logic [2:0] w_addr;
  logic [0:0] b_addr, out_index;
  logic [7:0] x_rdata, w_rdata, b_rdata, acc_data, acc_weight, out_data;
  logic [12:0] acc_sum;
  always #5 clk = ~clk;
  neuron_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .x_rd_en(x_rd_en), .x_addr(x_addr), .x_rdata(x_rdata),
    .w_addr(w_addr), .w_rdata(w_rdata),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
    .acc_clr(acc_clr), .acc_en(acc_en), .acc_data(acc_data), .acc_weight(acc_weight),
    .acc_sum(acc_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index)
  );
  logic [7:0] x_mem [NI];
  logic [7:0] w_mem [NI*NN];
  logic [7:0] b_mem [NN];
  always_ff @(posedge clk) begin
    if (x_rd_en) begin
      x_rdata <= x_mem[x_addr];
      w_rdata <= w_mem[w_addr];
    end
    if (b_rd_en) b_rdata <= b_mem[b_addr];
  end
  // perceptron: Q3.5*Q3.5 product rescaled to Q8.5, cleared by rst|acc_clr
  logic signed [15:0] prod;
  assign prod = $signed(acc_data) * $signed(acc_weight);
  always_ff @(posedge clk) begin
    if (rst || acc_clr) acc_sum <= '0;
    else if (acc_en) acc_sum <= acc_sum + 13'(prod >>> 5);
  end
  int cyc = 0, xr_cnt = 0, ae_cnt = 0, done_cnt = 0, clash = 0;
  int od[$], oi[$], hs_t[$], wlog[$];
  always @(negedge clk) begin
    cyc++;
    if (x_rd_en) begin
      xr_cnt++;
      wlog.push_back(int'(w_addr));
    end
    if (acc_en) ae_cnt++;
    if (acc_en && acc_clr) clash++;
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      od.push_back(int'(out_data));
      oi.push_back(int'(out_index));
      hs_t.push_back(cyc);
    end
  end
  int n_cmp = 0, n_bad = 0;
  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(logic [7:0] x, logic [7:0] w, logic [7:0] b0, logic [7:0] b1);
    for (int i = 0; i < NI; i++) x_mem[i] = x;
    for (int i = 0; i < NI*NN; i++) w_mem[i] = w;
    b_mem[0] = b0;
    b_mem[1] = b1;
  endtask
  task automatic wait_xrd(string tag);
    int t = 0;
    while (!x_rd_en && t < 20) begin
      tick();
      t++;
    end
    check({tag, "_xrd_seen"}, int'(x_rd_en), 1);
  endtask
  // mode 0: plain run, 1: extra start pulse during STREAM, 2: 5-cycle backpressure on neuron 0
  task automatic run_case(string tag, int mode, int e0, int e1);
    int xs = xr_cnt, as = ae_cnt, ds = done_cnt, hs = od.size(), ws = wlog.size();
    int t = 0, hold_ok = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, int'(busy), 1);
    if (mode == 1) begin
      wait_xrd(tag);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (mode == 2) begin
      while (!out_valid && t < 50) begin
        tick();
        t++;
      end
      for (int i = 0; i < 5; i++) begin
        if (!(out_valid && out_data == 8'(e0) && out_index == 1'b0 && !x_rd_en && !acc_en && !acc_clr))
          hold_ok = 0;
        tick();
      end
      check({tag, "_hold"}, hold_ok, 1);
      out_ready = 1'b1;
    end
    t = 0;
    while (!done && t < 200) begin
      tick();
      t++;
    end
    check({tag, "_done"}, int'(done), 1);
    tick();
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_idle"}, int'(busy), 0);
    check({tag, "_done_cnt"}, done_cnt - ds, 1);
    check({tag, "_xrd_cnt"}, xr_cnt - xs, NI*NN);
    check({tag, "_acc_en_cnt"}, ae_cnt - as, NI*NN);
    check({tag, "_clash"}, clash, 0);
    check({tag, "_hs_cnt"}, od.size() - hs, NN);
    if (od.size() - hs == NN) begin
      check({tag, "_out0"}, od[hs], e0);
      check({tag, "_out1"}, od[hs+1], e1);
      check({tag, "_idx0"}, oi[hs], 0);
      check({tag, "_idx1"}, oi[hs+1], 1);
      if (mode != 2) check({tag, "_period"}, hs_t[hs+1] - hs_t[hs], NI + 4);
    end
    if (wlog.size() - ws == NI*NN)
      for (int i = 0; i < NI*NN; i++) check({tag, "_waddr"}, wlog[ws+i], i);
  endtask
  initial begin
    load(8'd32, 8'd16, 8'd16, 8'd16);
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_xrd", int'(x_rd_en), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_clr", int'(acc_clr), 0);
    rst = 1'b0;
    tick();
    run_case("bias", 0, 80, 80);
    load(8'd32, 8'd32, 8'd0, 8'd0);
    run_case("sat", 0, 127, 127);
    load(8'd32, 8'hE0, 8'd8, 8'd8);
    run_case("relu", 0, 0, 0);
    load(8'd32, 8'd16, 8'd16, 8'd0);
    out_ready = 1'b0;
    run_case("bp", 2, 80, 64);
    load(8'd32, 8'd16, 8'd16, 8'd16);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_xrd("abort");
    tick();
    rst = 1'b1;
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_xrd", int'(x_rd_en), 0);
    check("abort_valid", int'(out_valid), 0);
    rst = 1'b0;
    tick();
    run_case("restart", 0, 80, 80);
    run_case("midstart", 1, 80, 80);
    repeat (5) tick();
    check("final_idle", int'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
